// File: rtl/spi_reg_peripheral_if.sv
// SPI pin bundle between an off-chip controller (master) and the register target (slave).
interface spi_reg_peripheral_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;
    logic cipo_oe;

    modport master (output sclk, output copi, output ncs, input cipo, input cipo_oe);
    modport slave  (input sclk, input copi, input ncs, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write target holding five PWM/output configuration bytes.
// Optional register readback on cipo is enabled by defining SPI_READBACK_EN.
module spi_reg_peripheral #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_reg_peripheral_if.slave  spi,
    output logic [7:0]           en_reg_out_7_0,
    output logic [7:0]           en_reg_out_15_8,
    output logic [7:0]           en_reg_pwm_7_0,
    output logic [7:0]           en_reg_pwm_15_8,
    output logic [7:0]           pwm_duty_cycle,
    output logic [1:0]           fsm_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [2:0] SETTLE_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
    logic                   sclk_d, ncs_d;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, ncs_rise, ncs_fall, frame_start;
    logic [2:0]             settle_cnt;
    logic                   settled;

    logic [1:0]  state;
    logic [15:0] shift_reg;
    logic [4:0]  bit_cnt;
    logic        overrun;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;

    // Synchronizers reset to the idle pin levels so reset release never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_d    <= 1'b0;
            ncs_d     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ncs_d     <= ncs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign ncs_rise  = ncs_s & ~ncs_d;
    assign ncs_fall  = ~ncs_s & ncs_d;

    // An ncs held low through reset flushes out of the synchronizer as a false falling
    // edge; ignore edges until the chain holds real post-reset samples.
    always_ff @(posedge clk) begin
        if (rst)
            settle_cnt <= 3'd0;
        else if (!settled)
            settle_cnt <= settle_cnt + 3'd1;
    end

    assign settled     = (settle_cnt == SETTLE_DONE);
    assign frame_start = ncs_fall & settled;
    assign fsm_state   = state;

    // Framing: a frame is the bits shifted while ncs is low; it commits only when exactly
    // 16 rising sclk edges were seen, bit 15 marks a write, and the address is in range.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            shift_reg <= 16'h0000;
            bit_cnt   <= 5'd0;
            overrun   <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= 7'd0;
            wr_data   <= 8'h00;
        end else begin
            wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        shift_reg <= 16'h0000;
                        bit_cnt   <= 5'd0;
                        overrun   <= 1'b0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ncs_rise) begin
                        state <= ST_COMMIT;
                    end else if (sclk_rise && !ncs_s) begin
                        shift_reg <= {shift_reg[14:0], copi_s};
                        if (bit_cnt == 5'd16)
                            overrun <= 1'b1;
                        else
                            bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                ST_COMMIT: begin
                    wr_en   <= (bit_cnt == 5'd16) && !overrun && shift_reg[15] &&
                               (shift_reg[14:8] <= MAX_ADDR);
                    wr_addr <= shift_reg[14:8];
                    wr_data <= shift_reg[7:0];
                    if (frame_start) begin
                        shift_reg <= 16'h0000;
                        bit_cnt   <= 5'd0;
                        overrun   <= 1'b0;
                        state     <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else if (wr_en) begin
            case (wr_addr)
                7'd0:    en_reg_out_7_0  <= wr_data;
                7'd1:    en_reg_out_15_8 <= wr_data;
                7'd2:    en_reg_pwm_7_0  <= wr_data;
                7'd3:    en_reg_pwm_15_8 <= wr_data;
                7'd4:    pwm_duty_cycle  <= wr_data;
                default: ;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic       sclk_fall;
    logic       is_read;
    logic [7:0] tx_reg;
    logic       cipo_q;
    logic [6:0] rd_addr;

    assign sclk_fall = ~sclk_s & sclk_d;
    assign rd_addr   = {shift_reg[5:0], copi_s};

    function automatic logic [7:0] read_mux(input logic [6:0] addr);
        logic [7:0] val;
        val = 8'h00;
        if (addr <= MAX_ADDR) begin
            case (addr)
                7'd0:    val = en_reg_out_7_0;
                7'd1:    val = en_reg_out_15_8;
                7'd2:    val = en_reg_pwm_7_0;
                7'd3:    val = en_reg_pwm_15_8;
                7'd4:    val = pwm_duty_cycle;
                default: val = 8'h00;
            endcase
        end
        return val;
    endfunction

    // The register is loaded as the last address bit arrives and shifted out MSB first on
    // falling edges, so the controller samples each data bit on the following rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_read <= 1'b0;
            tx_reg  <= 8'h00;
            cipo_q  <= 1'b0;
        end else if (state != ST_SHIFT && frame_start) begin
            is_read <= 1'b0;
            tx_reg  <= 8'h00;
            cipo_q  <= 1'b0;
        end else if (state == ST_SHIFT && !ncs_s) begin
            if (sclk_rise) begin
                if (bit_cnt == 5'd0)
                    is_read <= ~copi_s;
                if (bit_cnt == 5'd7)
                    tx_reg <= read_mux(rd_addr);
            end else if (sclk_fall && is_read && bit_cnt >= 5'd8) begin
                cipo_q <= tx_reg[7];
                tx_reg <= {tx_reg[6:0], 1'b0};
            end
        end
    end

    assign spi.cipo    = cipo_q;
    assign spi.cipo_oe = is_read && (state == ST_SHIFT) && !ncs_s;
`else
    assign spi.cipo    = 1'b0;
    assign spi.cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Self-checking bench for spi_reg_peripheral: bit-banged SPI frames, register scoreboard.
`timescale 1ns/1ps
module tb_spi_reg_peripheral;

    logic       clk;
    logic       rst;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic [1:0] fsm_state;

    spi_reg_peripheral_if spi ();

    spi_reg_peripheral dut (
        .clk             (clk),
        .rst             (rst),
        .spi             (spi),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .fsm_state       (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    logic [39:0] exp_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  mdl [0:4];
    logic [7:0]  rx_byte;
    int          oe_cnt = 0;

    wire [39:0] dut_regs = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
                            en_reg_pwm_15_8, pwm_duty_cycle};

    always @(negedge clk) if (spi.cipo_oe === 1'b1) oe_cnt = oe_cnt + 1;

    // driver tasks
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_xfer(input logic [15:0] frame, input int nbits, input bit keep_low);
        spi.ncs = 1'b0;
        wait_clk(5);
        for (int i = 0; i < nbits; i++) begin
            spi.copi = (i < 16) ? frame[15-i] : 1'b0;
            wait_clk(5);
            if (i >= 8) rx_byte = {rx_byte[6:0], spi.cipo};
            spi.sclk = 1'b1;
            wait_clk(5);
            spi.sclk = 1'b0;
        end
        wait_clk(5);
        if (!keep_low) spi.ncs = 1'b1;
    endtask

    function automatic logic [39:0] mdl_vec();
        return {mdl[0], mdl[1], mdl[2], mdl[3], mdl[4]};
    endfunction

    task automatic model_frame(input logic [15:0] frame, input int nbits);
        logic [6:0] a;
        a = frame[14:8];
        if (nbits == 16 && frame[15] && a <= 7'd4) mdl[a[2:0]] = frame[7:0];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
    endtask

    // scenarios
    task automatic test_reset();
        logic [39:0] e;
        rst = 1'b1;
        spi.sclk = 1'b0; spi.copi = 1'b0; spi.ncs = 1'b1;
        model_reset();
        wait_clk(5);
        exp_q.push_back(mdl_vec());
        e = exp_q.pop_front();
        checks++;
        if (dut_regs !== e) begin
            errors++; $display("FAIL reset_regs: actual=%h required=%h", dut_regs, e);
        end
        checks++;
        if (spi.cipo_oe !== 1'b0 || spi.cipo !== 1'b0) begin
            errors++; $display("FAIL reset_cipo: actual oe=%b cipo=%b required 0/0", spi.cipo_oe, spi.cipo);
        end
        checks++;
        if (fsm_state !== 2'd0) begin
            errors++; $display("FAIL reset_state: actual=%0d required=0", fsm_state);
        end
        rst = 1'b0;
        wait_clk(20);
        exp_q.push_back(mdl_vec());
        e = exp_q.pop_front();
        checks++;
        if (dut_regs !== e) begin
            errors++; $display("FAIL idle_after_reset: actual=%h required=%h", dut_regs, e);
        end
    endtask

    task automatic test_write();
        logic [39:0] e_old, e_new;
        int oe0;
        e_old = mdl_vec();
        oe0 = oe_cnt;
        model_frame(16'h81F0, 16);
        exp_q.push_back(mdl_vec());
        spi_xfer(16'h81F0, 16, 1'b0);
        wait_clk(4);
        checks++;
        if (dut_regs !== e_old) begin
            errors++; $display("FAIL write_early: actual=%h required=%h", dut_regs, e_old);
        end
        wait_clk(1);
        e_new = exp_q.pop_front();
        checks++;
        if (dut_regs !== e_new) begin
            errors++; $display("FAIL write_latency: actual=%h required=%h", dut_regs, e_new);
        end
        checks++;
        if (oe_cnt != oe0) begin
            errors++; $display("FAIL write_oe: actual oe cycles=%0d required=0", oe_cnt - oe0);
        end
    endtask

    task automatic test_pwm();
        logic [15:0] frames [2];
        logic [39:0] e;
        frames[0] = 16'h8480;
        frames[1] = 16'h8455;
        foreach (frames[k]) begin
            model_frame(frames[k], 16);
            exp_q.push_back(mdl_vec());
            spi_xfer(frames[k], 16, 1'b0);
            wait_clk(6);
            e = exp_q.pop_front();
            checks++;
            if (dut_regs !== e) begin
                errors++; $display("FAIL pwm_write_%0d: actual=%h required=%h", k, dut_regs, e);
            end
        end
    endtask

    task automatic test_bad_frames();
        logic [15:0] frames [3];
        int          lens   [3];
        logic [39:0] e;
        frames[0] = 16'h81AB; lens[0] = 15;
        frames[1] = 16'h80AB; lens[1] = 17;
        frames[2] = 16'h8533; lens[2] = 16;
        for (int k = 0; k < 3; k++) begin
            model_frame(frames[k], lens[k]);
            exp_q.push_back(mdl_vec());
            spi_xfer(frames[k], lens[k], 1'b0);
            wait_clk(8);
            e = exp_q.pop_front();
            checks++;
            if (dut_regs !== e) begin
                errors++; $display("FAIL bad_frame_%0d: actual=%h required=%h", k, dut_regs, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [39:0] e;
        spi_xfer(16'h82AA, 9, 1'b1);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        spi.ncs = 1'b1;
        model_reset();
        exp_q.push_back(mdl_vec());
        wait_clk(10);
        e = exp_q.pop_front();
        checks++;
        if (dut_regs !== e) begin
            errors++; $display("FAIL reset_mid_clear: actual=%h required=%h", dut_regs, e);
        end
        model_frame(16'h83CC, 16);
        exp_q.push_back(mdl_vec());
        spi_xfer(16'h83CC, 16, 1'b0);
        wait_clk(6);
        e = exp_q.pop_front();
        checks++;
        if (dut_regs !== e) begin
            errors++; $display("FAIL reset_mid_next: actual=%h required=%h", dut_regs, e);
        end
    endtask

    task automatic test_readback();
        logic [39:0] e;
        logic [7:0]  er;
        int oe0;
        model_frame(16'h8266, 16);
        exp_q.push_back(mdl_vec());
        spi_xfer(16'h8266, 16, 1'b0);
        wait_clk(6);
        e = exp_q.pop_front();
        checks++;
        if (dut_regs !== e) begin
            errors++; $display("FAIL rb_write: actual=%h required=%h", dut_regs, e);
        end
        oe0 = oe_cnt;
        model_frame(16'h0200, 16);
        exp_q.push_back(mdl_vec());
`ifdef SPI_READBACK_EN
        rx_q.push_back(mdl[2]);
`endif
        rx_byte = 8'h00;
        spi_xfer(16'h0200, 16, 1'b0);
        wait_clk(6);
        e = exp_q.pop_front();
        checks++;
        if (dut_regs !== e) begin
            errors++; $display("FAIL rb_read_no_write: actual=%h required=%h", dut_regs, e);
        end
`ifdef SPI_READBACK_EN
        er = rx_q.pop_front();
        checks++;
        if (rx_byte !== er) begin
            errors++; $display("FAIL rb_data: actual=%h required=%h", rx_byte, er);
        end
        checks++;
        if (oe_cnt == oe0) begin
            errors++; $display("FAIL rb_oe_active: actual oe cycles=0 required>0");
        end
`else
        er = 8'h00;
        checks++;
        if (oe_cnt != oe0 || spi.cipo !== er[0]) begin
            errors++; $display("FAIL rb_disabled: actual oe cycles=%0d cipo=%b required 0/0", oe_cnt - oe0, spi.cipo);
        end
`endif
        checks++;
        if (spi.cipo_oe !== 1'b0) begin
            errors++; $display("FAIL rb_oe_after: actual=%b required=0", spi.cipo_oe);
        end
    endtask

    // Second frame's ncs falls while the first frame is in its commit cycle.
    task automatic test_back_to_back();
        logic [15:0] a, b;
        logic [39:0] e;
        for (int k = 0; k < 4; k++) begin
            a = {1'b1, 7'($urandom_range(0, 4)), 8'($urandom_range(0, 255))};
            b = {1'b1, 7'($urandom_range(0, 4)), 8'($urandom_range(0, 255))};
            model_frame(a, 16);
            model_frame(b, 16);
            exp_q.push_back(mdl_vec());
            spi_xfer(a, 16, 1'b0);
            wait_clk(1);
            spi_xfer(b, 16, 1'b0);
            wait_clk(6);
            e = exp_q.pop_front();
            checks++;
            if (dut_regs !== e) begin
                errors++; $display("FAIL back_to_back_%0d: a=%h b=%h actual=%h required=%h", k, a, b, dut_regs, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        spi.ncs  = 1'b1;
        rx_byte  = 8'h00;
        test_reset();
        test_write();
        test_pwm();
        test_bad_frames();
        test_reset_mid();
        test_readback();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
